// File: rtl/hdmi_color_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_regs_pkg
// Description : Register map offsets and CTRL bit positions for the HDMI
//               colour register block.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_regs_pkg;

    localparam int NUM_COLOR_REGS = 6;

    localparam logic [2:0] OFS_RED_ON    = 3'd0;
    localparam logic [2:0] OFS_RED_OFF   = 3'd1;
    localparam logic [2:0] OFS_GREEN_ON  = 3'd2;
    localparam logic [2:0] OFS_GREEN_OFF = 3'd3;
    localparam logic [2:0] OFS_BLUE_ON   = 3'd4;
    localparam logic [2:0] OFS_BLUE_OFF  = 3'd5;
    localparam logic [2:0] OFS_CTRL      = 3'd6;

    localparam int CTRL_PENDING   = 0;
    localparam int CTRL_IMMEDIATE = 1;
    localparam int CTRL_FORCE     = 2;
    localparam int CTRL_FRAME     = 7;

    // Even offsets hold the "on" levels, odd offsets the "off" levels.
    function automatic logic [7:0] color_reset_value(input int idx,
                                                      input logic [7:0] on_val,
                                                      input logic [7:0] off_val);
        return ((idx % 2) == 0) ? on_val : off_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_color_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_color_regs_if
// Description : XLR8 register-bus bundle (address, strobes, data, read enable).
// Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_color_regs_if;
    logic [7:0] ramadr;
    logic       ramwe;
    logic       ramre;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       io_out_en;

    modport master (
        output ramadr, ramwe, ramre, dbus_in,
        input  dbus_out, io_out_en
    );

    modport slave (
        input  ramadr, ramwe, ramre, dbus_in,
        output dbus_out, io_out_en
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_color_regs_vsync.sv
`default_nettype none
// ============================================================================
// Module      : vsync_edge_detect
// Description : Two-flop synchronizer plus history flop; flags the transition
//               of async_in into the POL level.
// Revision    : 1.0 - initial release
// ============================================================================
module vsync_edge_detect #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= ~POL;
            r_s2 <= ~POL;
            r_s3 <= ~POL;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign edge_pulse = (r_s2 == POL) && (r_s3 != POL);

endmodule
`default_nettype wire

// File: rtl/hdmi_color_regs.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_color_regs
// Description : Shadow/active colour level registers; shadows are copied to
//               the active outputs on a vsync edge or a forced apply.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_color_regs
    import hdmi_regs_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter logic [7:0] RESET_ON  = 8'hFF,
    parameter logic [7:0] RESET_OFF = 8'h00,
    parameter logic       VSYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    hdmi_color_regs_if.slave  bus,
    input  logic              vsync_in,
    output logic [7:0]        red_on,
    output logic [7:0]        red_off,
    output logic [7:0]        green_on,
    output logic [7:0]        green_off,
    output logic [7:0]        blue_on,
    output logic [7:0]        blue_off,
    output logic              frame_tick
);

    logic [7:0] r_shadow [NUM_COLOR_REGS];
    logic [7:0] r_active [NUM_COLOR_REGS];
    logic       r_pending;
    logic       r_immediate;
    logic       r_force_req;
    logic       r_frame;
    logic       r_vsync_evt;
    logic       r_frame_tick;

    logic       w_vs_edge;
    logic       w_apply;
    logic [7:0] w_ofs;
    logic [2:0] w_idx;
    logic       w_hit;
    logic       w_wr_color;
    logic       w_wr_ctrl;
    logic [7:0] w_ctrl;

    vsync_edge_detect #(
        .POL        (VSYNC_POL)
    ) u_vsync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (vsync_in),
        .edge_pulse (w_vs_edge)
    );

    // Offset wraps modulo 256, so addresses below BASE_ADDR fall out of range.
    assign w_ofs      = bus.ramadr - BASE_ADDR;
    assign w_idx      = w_ofs[2:0];
    assign w_hit      = (w_ofs < 8'd7);
    assign w_wr_color = bus.ramwe && w_hit && (w_idx != OFS_CTRL);
    assign w_wr_ctrl  = bus.ramwe && w_hit && (w_idx == OFS_CTRL);
    assign w_apply    = r_vsync_evt || r_force_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COLOR_REGS; i++) begin
                r_shadow[i] <= color_reset_value(i, RESET_ON, RESET_OFF);
                r_active[i] <= color_reset_value(i, RESET_ON, RESET_OFF);
            end
            r_pending    <= 1'b0;
            r_immediate  <= 1'b0;
            r_force_req  <= 1'b0;
            r_frame      <= 1'b0;
            r_vsync_evt  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vsync_evt  <= w_vs_edge;
            r_frame_tick <= w_apply;
            r_force_req  <= w_wr_ctrl && bus.dbus_in[CTRL_FORCE];

            if (w_apply) begin
                r_frame <= ~r_frame;
            end

            if (w_wr_ctrl) begin
                r_immediate <= bus.dbus_in[CTRL_IMMEDIATE];
            end

            // A deferred write landing with an apply still leaves work pending.
            if (w_wr_color && !r_immediate) begin
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            for (int i = 0; i < NUM_COLOR_REGS; i++) begin
                if (w_wr_color && (w_idx == 3'(i))) begin
                    r_shadow[i] <= bus.dbus_in;
                end
                if (w_wr_color && r_immediate && (w_idx == 3'(i))) begin
                    r_active[i] <= bus.dbus_in;
                end else if (w_apply) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_comb begin
        w_ctrl                 = 8'h00;
        w_ctrl[CTRL_PENDING]   = r_pending;
        w_ctrl[CTRL_IMMEDIATE] = r_immediate;
        w_ctrl[CTRL_FRAME]     = r_frame;
    end

    always_comb begin
        bus.dbus_out  = 8'h00;
        bus.io_out_en = 1'b0;
        if (bus.ramre && w_hit) begin
            bus.io_out_en = 1'b1;
            if (w_idx == OFS_CTRL) begin
                bus.dbus_out = w_ctrl;
            end else begin
                bus.dbus_out = r_shadow[w_idx];
            end
        end
    end

    assign red_on     = r_active[OFS_RED_ON];
    assign red_off    = r_active[OFS_RED_OFF];
    assign green_on   = r_active[OFS_GREEN_ON];
    assign green_off  = r_active[OFS_GREEN_OFF];
    assign blue_on    = r_active[OFS_BLUE_ON];
    assign blue_off   = r_active[OFS_BLUE_OFF];
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_color_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_color_regs
// Description : Directed testbench for hdmi_color_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_color_regs;

    logic       clk;
    logic       rst;
    logic       vsync_in;
    logic [7:0] red_on, red_off, green_on, green_off, blue_on, blue_off;
    logic       frame_tick;
    int         n_vec;
    int         n_err;

    hdmi_color_regs_if bus ();

    hdmi_color_regs #(
        .BASE_ADDR (8'hE0),
        .RESET_ON  (8'hFF),
        .RESET_OFF (8'h00),
        .VSYNC_POL (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .vsync_in   (vsync_in),
        .red_on     (red_on),
        .red_off    (red_off),
        .green_on   (green_on),
        .green_off  (green_off),
        .blue_on    (blue_on),
        .blue_off   (blue_off),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [7:0] data);
        bus.ramadr  = adr;
        bus.dbus_in = data;
        bus.ramwe   = 1'b1;
        tick();
        bus.ramwe   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] adr, input string tag,
                            input logic [7:0] exp_data, input logic exp_en);
        bus.ramadr = adr;
        bus.ramre  = 1'b1;
        #2;
        chk({tag, "_data"}, bus.dbus_out, exp_data);
        chk({tag, "_en"}, {7'd0, bus.io_out_en}, {7'd0, exp_en});
        bus.ramre  = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        vsync_in    = 1'b0;
        bus.ramadr  = 8'h00;
        bus.ramwe   = 1'b0;
        bus.ramre   = 1'b0;
        bus.dbus_in = 8'h00;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_red_on", red_on, 8'hFF);
        chk("rst_red_off", red_off, 8'h00);
        chk("rst_green_on", green_on, 8'hFF);
        chk("rst_blue_off", blue_off, 8'h00);
        chk("rst_frame_tick", {7'd0, frame_tick}, 8'h00);
        bus_read(8'hE6, "rst_ctrl", 8'h00, 1'b1);
        bus_read(8'hE0, "rst_sh0", 8'hFF, 1'b1);
        bus_read(8'hE1, "rst_sh1", 8'h00, 1'b1);
        bus_read(8'hE2, "rst_sh2", 8'hFF, 1'b1);
        bus_read(8'hE3, "rst_sh3", 8'h00, 1'b1);
        bus_read(8'hE4, "rst_sh4", 8'hFF, 1'b1);
        bus_read(8'hE5, "rst_sh5", 8'h00, 1'b1);

        // Deferred apply through vsync
        bus_write(8'hE0, 8'h40);
        bus_read(8'hE0, "def_shadow", 8'h40, 1'b1);
        chk("def_red_on_hold", red_on, 8'hFF);
        bus_read(8'hE6, "def_ctrl_pend", 8'h01, 1'b1);
        vsync_in = 1'b1;
        tick();
        tick();
        tick();
        chk("def_edge3_red_on", red_on, 8'hFF);
        chk("def_edge3_tick", {7'd0, frame_tick}, 8'h00);
        tick();
        chk("def_edge4_red_on", red_on, 8'h40);
        chk("def_edge4_tick", {7'd0, frame_tick}, 8'h01);
        bus_read(8'hE6, "def_ctrl_frame", 8'h80, 1'b1);
        tick();
        chk("def_tick_one_cycle", {7'd0, frame_tick}, 8'h00);
        vsync_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("def_fall_no_tick", {7'd0, frame_tick}, 8'h00);
        end
        bus_read(8'hE6, "def_ctrl_after_fall", 8'h80, 1'b1);

        // IMMEDIATE mode
        bus_write(8'hE6, 8'h02);
        bus_write(8'hE3, 8'h11);
        chk("imm_green_off", green_off, 8'h11);
        bus_read(8'hE6, "imm_ctrl", 8'h82, 1'b1);
        bus_write(8'hE6, 8'h00);
        bus_read(8'hE6, "imm_ctrl_off", 8'h80, 1'b1);

        // FORCE: second apply toggles FRAME back to 0
        bus_write(8'hE5, 8'h22);
        bus_read(8'hE6, "frc_ctrl_pend", 8'h81, 1'b1);
        chk("frc_blue_off_hold", blue_off, 8'h00);
        bus_write(8'hE6, 8'h04);
        chk("frc_write_edge", blue_off, 8'h00);
        tick();
        chk("frc_blue_off", blue_off, 8'h22);
        chk("frc_tick", {7'd0, frame_tick}, 8'h01);
        bus_read(8'hE6, "frc_ctrl", 8'h00, 1'b1);
        tick();
        chk("frc_tick_clear", {7'd0, frame_tick}, 8'h00);

        // Collision: shadow write in the apply cycle
        bus_write(8'hE0, 8'h10);
        vsync_in = 1'b1;
        tick();
        tick();
        tick();
        bus_write(8'hE0, 8'h20);
        chk("col_red_on", red_on, 8'h10);
        chk("col_tick", {7'd0, frame_tick}, 8'h01);
        bus_read(8'hE0, "col_shadow", 8'h20, 1'b1);
        bus_read(8'hE6, "col_ctrl", 8'h81, 1'b1);
        vsync_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        vsync_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("col_second_red_on", red_on, 8'h20);
        bus_read(8'hE6, "col_ctrl2", 8'h00, 1'b1);
        vsync_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // FORCE coinciding with a vsync apply: one toggle, one pulse
        vsync_in = 1'b1;
        tick();
        tick();
        bus_write(8'hE6, 8'h04);
        chk("both_pre_tick", {7'd0, frame_tick}, 8'h00);
        tick();
        chk("both_tick", {7'd0, frame_tick}, 8'h01);
        tick();
        chk("both_tick_clear", {7'd0, frame_tick}, 8'h00);
        bus_read(8'hE6, "both_ctrl", 8'h80, 1'b1);
        vsync_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Address decode limits
        bus_write(8'hE7, 8'h55);
        bus_write(8'hDF, 8'h55);
        tick();
        chk("dec_red_on", red_on, 8'h20);
        chk("dec_blue_off", blue_off, 8'h22);
        bus_read(8'hE0, "dec_sh0", 8'h20, 1'b1);
        bus_read(8'hE5, "dec_sh5", 8'h22, 1'b1);
        bus_read(8'hE6, "dec_ctrl", 8'h80, 1'b1);
        bus_read(8'hE7, "dec_rd_hi", 8'h00, 1'b0);
        bus_read(8'hDF, "dec_rd_lo", 8'h00, 1'b0);
        bus.ramadr = 8'hE0;
        #1;
        chk("dec_no_re_data", bus.dbus_out, 8'h00);
        chk("dec_no_re_en", {7'd0, bus.io_out_en}, 8'h00);

        // Reset mid-operation clears an in-flight FORCE
        bus_write(8'hE1, 8'h77);
        bus.ramadr  = 8'hE6;
        bus.dbus_in = 8'h04;
        bus.ramwe   = 1'b1;
        tick();
        bus.ramwe   = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_red_off", red_off, 8'h00);
        chk("mid_rst_tick", {7'd0, frame_tick}, 8'h00);
        tick();
        chk("mid_rst_red_off2", red_off, 8'h00);
        chk("mid_rst_red_on", red_on, 8'hFF);
        bus_read(8'hE6, "mid_rst_ctrl", 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
